// File: rtl/mac_tx_framer.sv
// Transmit framer: wraps a raw MAC byte stream into a GMII Ethernet frame
// (preamble/SFD, zero pad, CRC-32 FCS, inter-frame gap) with underrun and error marking.
module mac_tx_framer #(
   parameter int IFG_BYTES  = 12,
   parameter int MIN_FRAME  = 60,
   parameter int ENABLE_FCS = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] mac_tdata_in,
   input  logic       mac_tvalid_in,
   input  logic       mac_tlast_in,
   input  logic       mac_tuser_in,
   output logic       mac_tready_out,
   output logic [7:0] phy_txd_out,
   output logic       phy_tvalid_out,
   output logic       phy_terr_out,
   input  logic       phy_tready_in,
   output logic       tx_underrun_out
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_PAD  = 3'd3;
   localparam logic [2:0] S_FCS  = 3'd4;
   localparam logic [2:0] S_DROP = 3'd5;
   localparam logic [2:0] S_IFG  = 3'd6;

   localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
   localparam logic [10:0] LEN_MAX      = 11'h7FF;
   localparam logic [10:0] MIN_LEN      = 11'(MIN_FRAME);
   localparam logic [15:0] IFG_LAST     = 16'(IFG_BYTES - 1);
   localparam logic [2:0]  S_AFTER_BODY = (ENABLE_FCS != 0) ? S_FCS : S_IFG;

   logic [2:0]  r_state;
   logic [15:0] r_cnt;
   logic [10:0] r_len;
   logic [31:0] r_crc;
   logic        r_bad;
   logic [7:0]  r_txd;
   logic        r_tvalid;
   logic        r_terr;
   logic        r_underrun;

   logic [10:0] w_len_inc;
   logic        w_need_pad;
   logic [31:0] w_crc_data;
   logic [31:0] w_crc_pad;
   logic [31:0] w_fcs;
   logic [7:0]  w_fcs_byte;

   // Reflected CRC-32, one data bit per iteration, LSB of the byte first.
   function automatic logic [31:0] crc8_next(input logic [31:0] crc_in, input logic [7:0] data_in);
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ data_in[i]) ? ({1'b0, c[31:1]} ^ CRC_POLY) : {1'b0, c[31:1]};
      end
      return c;
   endfunction

   assign w_len_inc  = (r_len == LEN_MAX) ? r_len : r_len + 11'd1;
   assign w_crc_data = crc8_next(r_crc, mac_tdata_in);
   assign w_crc_pad  = crc8_next(r_crc, 8'h00);
   assign w_fcs      = ~r_crc;

   generate
      if (MIN_FRAME > 0) begin : g_pad
         assign w_need_pad = (w_len_inc < MIN_LEN);
      end else begin : g_nopad
         assign w_need_pad = 1'b0;
      end
   endgenerate

   always_comb begin
      w_fcs_byte = w_fcs[7:0];
      case (r_cnt[1:0])
         2'd1:    w_fcs_byte = w_fcs[15:8];
         2'd2:    w_fcs_byte = w_fcs[23:16];
         2'd3:    w_fcs_byte = w_fcs[31:24];
         default: w_fcs_byte = w_fcs[7:0];
      endcase
   end

   assign mac_tready_out  = phy_tready_in & ((r_state == S_DATA) | (r_state == S_DROP));
   assign phy_txd_out     = r_txd;
   assign phy_tvalid_out  = r_tvalid;
   assign phy_terr_out    = r_terr;
   assign tx_underrun_out = r_underrun;

   // A low phy_tready_in freezes every register, outputs included.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_len      <= '0;
         r_crc      <= 32'hFFFFFFFF;
         r_bad      <= 1'b0;
         r_txd      <= 8'h00;
         r_tvalid   <= 1'b0;
         r_terr     <= 1'b0;
         r_underrun <= 1'b0;
      end else if (phy_tready_in) begin
         r_underrun <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_txd    <= 8'h00;
               r_tvalid <= 1'b0;
               r_terr   <= 1'b0;
               // The waiting first byte stays on the input until DATA.
               if (mac_tvalid_in) begin
                  r_txd    <= 8'h55;
                  r_tvalid <= 1'b1;
                  r_cnt    <= 16'd1;
                  r_crc    <= 32'hFFFFFFFF;
                  r_len    <= '0;
                  r_bad    <= 1'b0;
                  r_state  <= S_PRE;
               end
            end
            S_PRE: begin
               r_tvalid <= 1'b1;
               r_terr   <= 1'b0;
               if (r_cnt == 16'd7) begin
                  r_txd   <= 8'hD5;
                  r_cnt   <= '0;
                  r_state <= S_DATA;
               end else begin
                  r_txd <= 8'h55;
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (mac_tvalid_in) begin
                  r_txd    <= mac_tdata_in;
                  r_tvalid <= 1'b1;
                  r_terr   <= 1'b0;
                  r_crc    <= w_crc_data;
                  r_len    <= w_len_inc;
                  if (mac_tlast_in) begin
                     r_bad   <= mac_tuser_in;
                     r_cnt   <= '0;
                     r_state <= w_need_pad ? S_PAD : S_AFTER_BODY;
                  end
               end else begin
                  // Upstream ran dry mid-frame: poison one byte and discard the rest.
                  r_txd      <= 8'h00;
                  r_tvalid   <= 1'b1;
                  r_terr     <= 1'b1;
                  r_underrun <= 1'b1;
                  r_state    <= S_DROP;
               end
            end
            S_PAD: begin
               r_txd    <= 8'h00;
               r_tvalid <= 1'b1;
               r_terr   <= 1'b0;
               r_crc    <= w_crc_pad;
               r_len    <= w_len_inc;
               if (w_len_inc == MIN_LEN) begin
                  r_cnt   <= '0;
                  r_state <= S_AFTER_BODY;
               end
            end
            S_FCS: begin
               r_txd    <= w_fcs_byte;
               r_tvalid <= 1'b1;
               r_terr   <= r_bad;
               if (r_cnt[1:0] == 2'd3) begin
                  r_cnt   <= '0;
                  r_state <= S_IFG;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DROP: begin
               r_txd    <= 8'h00;
               r_tvalid <= 1'b0;
               r_terr   <= 1'b0;
               if (mac_tvalid_in && mac_tlast_in) begin
                  r_cnt   <= '0;
                  r_state <= S_IFG;
               end
            end
            S_IFG: begin
               r_txd    <= 8'h00;
               r_tvalid <= 1'b0;
               r_terr   <= 1'b0;
               if (r_cnt == IFG_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_txd    <= 8'h00;
               r_tvalid <= 1'b0;
               r_terr   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: directed frames push expected PHY beats,
// a negedge monitor pops and compares every accepted beat.
module tb_mac_tx_framer;

   localparam int IFG = 12;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [7:0] drv_data = 8'h00;
   logic       drv_valid = 1'b0;
   logic       drv_last = 1'b0;
   logic       drv_user = 1'b0;
   logic       drv_np = 1'b0;
   logic       phy_tready = 1'b1;
   logic       stall_en = 1'b0;

   logic       a_tvalid_in, n_tvalid_in;
   logic       a_mac_tready, n_mac_tready;
   logic [7:0] a_txd, n_txd;
   logic       a_pvalid, n_pvalid;
   logic       a_terr, n_terr;
   logic       a_underrun, n_underrun;

   assign a_tvalid_in = drv_valid & ~drv_np;
   assign n_tvalid_in = drv_valid & drv_np;

   always #5 sys_clk = ~sys_clk;

   mac_tx_framer u_dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .mac_tdata_in(drv_data), .mac_tvalid_in(a_tvalid_in), .mac_tlast_in(drv_last), .mac_tuser_in(drv_user),
      .mac_tready_out(a_mac_tready),
      .phy_txd_out(a_txd), .phy_tvalid_out(a_pvalid), .phy_terr_out(a_terr),
      .phy_tready_in(phy_tready), .tx_underrun_out(a_underrun)
   );

   mac_tx_framer #(.IFG_BYTES(12), .MIN_FRAME(0), .ENABLE_FCS(1)) u_dut_np (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .mac_tdata_in(drv_data), .mac_tvalid_in(n_tvalid_in), .mac_tlast_in(drv_last), .mac_tuser_in(drv_user),
      .mac_tready_out(n_mac_tready),
      .phy_txd_out(n_txd), .phy_tvalid_out(n_pvalid), .phy_terr_out(n_terr),
      .phy_tready_in(phy_tready), .tx_underrun_out(n_underrun)
   );

   int         npass = 0;
   int         ntotal = 0;
   logic [8:0] sb_q[$];
   int         gap_q[$];
   int         idle_run = 0;
   logic       a_prev_valid = 1'b0;
   int         beat_cnt_a = 0;
   int         underrun_cnt = 0;
   logic [7:0] frame_buf [0:127];

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (ok) npass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   task automatic take_beat(input logic [8:0] act, input string name);
      logic [8:0] exp;
      if (sb_q.size() == 0) begin
         check(1'b0, {"unexpected_beat_", name}, 32'(act), 32'h1FF);
      end else begin
         exp = sb_q.pop_front();
         check(act == exp, {"beat_", name}, 32'(act), 32'(exp));
      end
   endtask

   always @(negedge sys_clk) begin
      if (phy_tready) begin
         if (a_pvalid) begin
            take_beat({a_terr, a_txd}, "a");
            beat_cnt_a++;
            if (!a_prev_valid) gap_q.push_back(idle_run);
            idle_run = 0;
         end else begin
            idle_run++;
         end
         a_prev_valid = a_pvalid;
         if (n_pvalid) take_beat({n_terr, n_txd}, "np");
         if (a_underrun) underrun_cnt++;
      end else begin
         check(!a_mac_tready && !n_mac_tready, "ready_low_in_stall", 32'({a_mac_tready, n_mac_tready}), 32'h0);
      end
   end

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         phy_tready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_pre();
      for (int k = 0; k < 7; k++) sb_q.push_back({1'b0, 8'h55});
      sb_q.push_back({1'b0, 8'hD5});
   endtask

   task automatic push_model(input int n, input bit bad, input int min_len);
      logic [31:0] crc;
      int len;
      crc = 32'hFFFFFFFF;
      len = 0;
      push_pre();
      for (int k = 0; k < n; k++) begin
         sb_q.push_back({1'b0, frame_buf[k]});
         crc = crc_model(crc, frame_buf[k]);
         len++;
      end
      while (len < min_len) begin
         sb_q.push_back(9'h000);
         crc = crc_model(crc, 8'h00);
         len++;
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) sb_q.push_back({bad, crc[8*k +: 8]});
   endtask

   task automatic present(input int i, input int n, input bit tuser);
      drv_data = (i < n) ? frame_buf[i] : 8'h00;
      drv_last = (i == n - 1);
      drv_user = tuser && (i == n - 1);
   endtask

   // Leaves drv_valid as it is on return so frames can be chained.
   task automatic drive_frame(input int n, input int stop_after, input bit tuser, input int gap_at, input bit tgt_np);
      int  i;
      int  budget;
      bit  hs;
      bit  gapped;
      i = 0;
      budget = 0;
      gapped = 0;
      drv_np = tgt_np;
      present(0, n, tuser);
      drv_valid = 1'b1;
      while (i < stop_after) begin
         @(negedge sys_clk);
         hs = drv_valid && (tgt_np ? n_mac_tready : a_mac_tready);
         @(posedge sys_clk);
         #1;
         if (hs) i++;
         if (!drv_valid) drv_valid = 1'b1;
         else if (hs && i == gap_at && !gapped) begin
            drv_valid = 1'b0;
            gapped = 1;
         end
         present(i, n, tuser);
         budget++;
         if (budget > 3000) begin
            check(1'b0, "drive_timeout", 32'(i), 32'(stop_after));
            break;
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 3000) begin
         @(posedge sys_clk);
         t++;
      end
      stall_en = 1'b0;
      repeat (IFG + 6) @(posedge sys_clk);
      #1;
      check(sb_q.size() == 0, name, 32'(sb_q.size()), 32'h0);
      sb_q.delete();
   endtask

   initial begin
      int uc0;
      int bc0;
      int g;

      repeat (3) @(posedge sys_clk);
      #1;
      check(a_pvalid == 1'b0, "rst_tvalid", 32'(a_pvalid), 32'h0);
      check(a_txd == 8'h00, "rst_txd", 32'(a_txd), 32'h0);
      check(a_terr == 1'b0, "rst_terr", 32'(a_terr), 32'h0);
      check(a_underrun == 1'b0, "rst_underrun", 32'(a_underrun), 32'h0);
      check(a_mac_tready == 1'b0, "rst_mac_tready", 32'(a_mac_tready), 32'h0);
      check(n_pvalid == 1'b0, "rst_np_tvalid", 32'(n_pvalid), 32'h0);
      sys_rst = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;

      // "123456789" without padding; FCS 26 39 F4 CB.
      for (int k = 0; k < 9; k++) frame_buf[k] = 8'(8'h31 + k);
      push_pre();
      for (int k = 0; k < 9; k++) sb_q.push_back({1'b0, 8'(8'h31 + k)});
      sb_q.push_back(9'h026);
      sb_q.push_back(9'h039);
      sb_q.push_back(9'h0F4);
      sb_q.push_back(9'h0CB);
      drive_frame(9, 9, 1'b0, -1, 1'b1);
      drv_valid = 1'b0;
      wait_drain("drain_crc_check");

      // 1-byte frame padded to 60.
      frame_buf[0] = 8'hAA;
      bc0 = beat_cnt_a;
      push_model(1, 1'b0, 60);
      drive_frame(1, 1, 1'b0, -1, 1'b0);
      drv_valid = 1'b0;
      wait_drain("drain_short");
      check(beat_cnt_a - bc0 == 72, "short_total_beats", 32'(beat_cnt_a - bc0), 32'd72);

      // Back-to-back 64-byte frames with tvalid held.
      for (int k = 0; k < 64; k++) frame_buf[k] = 8'(k);
      gap_q.delete();
      push_model(64, 1'b0, 60);
      push_model(64, 1'b0, 60);
      drive_frame(64, 64, 1'b0, -1, 1'b0);
      drive_frame(64, 64, 1'b0, -1, 1'b0);
      drv_valid = 1'b0;
      wait_drain("drain_b2b");
      check(gap_q.size() == 2, "b2b_frame_count", 32'(gap_q.size()), 32'd2);
      g = (gap_q.size() >= 2) ? gap_q[1] : -1;
      check(g == IFG, "b2b_gap", 32'(g), 32'(IFG));

      // Underrun at data byte 10.
      uc0 = underrun_cnt;
      push_pre();
      for (int k = 0; k < 10; k++) sb_q.push_back({1'b0, frame_buf[k]});
      sb_q.push_back(9'h100);
      drive_frame(64, 64, 1'b0, 10, 1'b0);
      drv_valid = 1'b0;
      wait_drain("drain_underrun");
      check(underrun_cnt - uc0 == 1, "underrun_pulse", 32'(underrun_cnt - uc0), 32'd1);

      // Bad frame: tuser on tlast, no pad needed.
      uc0 = underrun_cnt;
      push_model(64, 1'b1, 60);
      drive_frame(64, 64, 1'b1, -1, 1'b0);
      drv_valid = 1'b0;
      wait_drain("drain_bad");
      check(underrun_cnt == uc0, "bad_no_underrun", 32'(underrun_cnt - uc0), 32'd0);

      // 100-byte frame under random PHY back-pressure.
      for (int k = 0; k < 100; k++) frame_buf[k] = 8'(k * 7 + 3);
      push_model(100, 1'b0, 60);
      stall_en = 1'b1;
      drive_frame(100, 100, 1'b0, -1, 1'b0);
      drv_valid = 1'b0;
      wait_drain("drain_stall");

      // Reset at data byte 20, then an immediate new frame.
      for (int k = 0; k < 64; k++) frame_buf[k] = 8'(8'hC0 + k);
      push_pre();
      for (int k = 0; k < 20; k++) sb_q.push_back({1'b0, frame_buf[k]});
      drive_frame(64, 20, 1'b0, -1, 1'b0);
      sys_rst = 1'b1;
      drv_valid = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      check(a_pvalid == 1'b0, "midrst_tvalid", 32'(a_pvalid), 32'h0);
      check(a_txd == 8'h00, "midrst_txd", 32'(a_txd), 32'h0);
      check(a_terr == 1'b0, "midrst_terr", 32'(a_terr), 32'h0);
      check(a_mac_tready == 1'b0, "midrst_mac_tready", 32'(a_mac_tready), 32'h0);
      check(sb_q.size() == 0, "midrst_truncated", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
      push_model(64, 1'b0, 60);
      fork
         drive_frame(64, 64, 1'b0, -1, 1'b0);
         begin
            @(posedge sys_clk);
            #1;
            check(a_pvalid && a_txd == 8'h55, "postrst_preamble", 32'({a_pvalid, a_txd}), 32'h155);
         end
      join
      drv_valid = 1'b0;
      wait_drain("drain_postrst");

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
